// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - gates ADC samples into FFT frames and reports the strongest non-DC bin
// The core is held in reset (fft_reset_o) in IDLE and HOLD; all other states let it run.
module fft_frame_scheduler #(
  parameter int FFT_LENGTH   = 1024,
  parameter int IDX_W        = 10,
  parameter int SCAN_BINS    = 512,
  parameter int RESET_CYCLES = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    adc_valid_i,
  input  logic signed [15:0]      adc_data_i,
  output logic                    fft_reset_o,
  output logic                    fft_stream_active_o,
  output logic signed [15:0]      fft_real_o,
  input  logic                    fft_done_i,
  output logic [IDX_W-1:0]        fft_index_o,
  input  logic [15:0]             fft_mag_i,
  input  logic                    fft_mag_ready_i,
  output logic [IDX_W-1:0]        peak_bin_o,
  output logic [15:0]             peak_mag_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    busy_o,
  output logic [15:0]             dropped_o
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_WAIT_FFT,
    S_SCAN,
    S_REPORT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  sample_cnt;
  logic              load_take;

  assign load_take = (state == S_LOAD) && adc_valid_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    fft_reset_o   = 1'b0;
    frame_valid_o = 1'b0;
    busy_o        = 1'b1;
    case (state)
      S_IDLE: begin
        fft_reset_o = 1'b1;
        busy_o      = 1'b0;
        if (enable) next_state = S_HOLD;
      end
      S_HOLD: begin
        fft_reset_o = 1'b1;
        if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (load_take && sample_cnt == IDX_W'(FFT_LENGTH - 1)) next_state = S_WAIT_FFT;
      end
      S_WAIT_FFT: begin
        if (fft_done_i) next_state = S_SCAN;
      end
      S_SCAN: begin
        if (fft_mag_ready_i && fft_index_o == IDX_W'(SCAN_BINS - 1)) next_state = S_REPORT;
      end
      S_REPORT: begin
        frame_valid_o = 1'b1;
        if (frame_ready_i) next_state = enable ? S_HOLD : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fft_stream_active_o <= 1'b0;
      fft_real_o          <= '0;
      fft_index_o         <= '0;
      peak_bin_o          <= '0;
      peak_mag_o          <= '0;
      dropped_o           <= '0;
      hold_cnt            <= '0;
      sample_cnt          <= '0;
    end else begin
      fft_stream_active_o <= load_take;
      if (load_take) begin
        fft_real_o <= adc_data_i;
        sample_cnt <= sample_cnt + IDX_W'(1);
      end
      // Anything arriving outside LOAD, including the handshake cycle, is lost.
      if (adc_valid_i && state != S_LOAD && dropped_o != 16'hFFFF) begin
        dropped_o <= dropped_o + 16'd1;
      end
      case (state)
        S_IDLE: hold_cnt <= '0;
        S_HOLD: begin
          hold_cnt   <= hold_cnt + HOLD_W'(1);
          sample_cnt <= '0;
        end
        S_WAIT_FFT: begin
          fft_index_o <= IDX_W'(1);
          peak_mag_o  <= '0;
          peak_bin_o  <= IDX_W'(1);
        end
        S_SCAN: begin
          if (fft_mag_ready_i) begin
            // Strict compare: on a tie the earlier (lower) bin is kept.
            if (fft_mag_i > peak_mag_o) begin
              peak_mag_o <= fft_mag_i;
              peak_bin_o <= fft_index_o;
            end
            fft_index_o <= fft_index_o + IDX_W'(1);
          end
        end
        S_REPORT: hold_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - randomized bench with a behavioural FFT core and peak reference
module tb_fft_frame_scheduler;

  localparam int N    = 1024;
  localparam int IW   = 10;
  localparam int BINS = 512;
  localparam int RC   = 20;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               adc_valid_i;
  logic signed [15:0] adc_data_i;
  logic               fft_reset_o;
  logic               fft_stream_active_o;
  logic signed [15:0] fft_real_o;
  logic               fft_done_i;
  logic [IW-1:0]      fft_index_o;
  logic [15:0]        fft_mag_i;
  logic               fft_mag_ready_i;
  logic [IW-1:0]      peak_bin_o;
  logic [15:0]        peak_mag_o;
  logic               frame_valid_o;
  logic               frame_ready_i;
  logic               busy_o;
  logic [15:0]        dropped_o;

  fft_frame_scheduler #(
    .FFT_LENGTH(N), .IDX_W(IW), .SCAN_BINS(BINS), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
    .fft_reset_o(fft_reset_o), .fft_stream_active_o(fft_stream_active_o),
    .fft_real_o(fft_real_o), .fft_done_i(fft_done_i), .fft_index_o(fft_index_o),
    .fft_mag_i(fft_mag_i), .fft_mag_ready_i(fft_mag_ready_i),
    .peak_bin_o(peak_bin_o), .peak_mag_o(peak_mag_o),
    .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i),
    .busy_o(busy_o), .dropped_o(dropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drops = 0;
  int fwd_count = 0;
  int core_mode = 0;
  int core_cnt  = 0;
  int drv_n     = 0;
  int samp    [0:N-1];
  int mag_tab [0:(1<<IW)-1];
  real ct [0:N-1];
  real st [0:N-1];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] sine_sample(input int n);
    real t, v;
    t = 2.0 * 3.14159265358979 * n / N;
    v = 16000.0 * (0.9 * $sin(8.0 * t) + 0.5 * $sin(19.0 * t) + 0.3 * $sin(30.0 * t));
    return 16'($rtoi(v));
  endfunction

  // Magnitudes the core will report for the frame just captured.
  task automatic build_table();
    for (int k = 0; k < (1 << IW); k++) mag_tab[k] = 0;
    if (core_mode == 1) begin
      for (int k = 1; k < BINS; k++) begin
        real re, im, m;
        re = 0.0; im = 0.0;
        for (int n = 0; n < N; n++) begin
          re += samp[n] * ct[(k * n) % N];
          im -= samp[n] * st[(k * n) % N];
        end
        m = $sqrt(re * re + im * im) / N;
        mag_tab[k] = (m > 65535.0) ? 65535 : $rtoi(m);
      end
    end else if (core_mode == 2) begin
      for (int k = 1; k < BINS; k++) mag_tab[k] = 10;
      mag_tab[5] = 100;
      mag_tab[9] = 100;
    end else begin
      for (int k = 1; k < BINS; k++) mag_tab[k] = int'($urandom_range(0, 60000));
      if ($urandom_range(0, 1) == 1) begin
        mag_tab[$urandom_range(1, BINS - 1)] = 65535;
        mag_tab[$urandom_range(1, BINS - 1)] = 65535;
      end
    end
  endtask

  // Reference: the largest magnitude, reported at the lowest bin that carries it.
  task automatic ref_peak(output int b, output int m);
    m = 0;
    for (int k = 1; k < BINS; k++) if (mag_tab[k] > m) m = mag_tab[k];
    b = 1;
    for (int k = BINS - 1; k >= 1; k--) if (mag_tab[k] == m) b = k;
  endtask

  initial begin : core_model
    int phase, delay, scan_idx;
    phase = 0; delay = 0; scan_idx = 1;
    fft_done_i = 1'b0; fft_mag_ready_i = 1'b0; fft_mag_i = '0;
    forever begin
      @(negedge clk);
      fft_done_i = 1'b0;
      if (fft_reset_o) begin
        phase = 0; core_cnt = 0; fft_mag_ready_i = 1'b0;
      end else begin
        case (phase)
          0: if (fft_stream_active_o && core_cnt < N) begin
            samp[core_cnt] = int'(fft_real_o);
            core_cnt++;
            if (core_cnt == N) begin
              build_table();
              phase = 1;
              delay = int'($urandom_range(20, 60));
            end
          end
          1: if (delay == 0) begin
            fft_done_i = 1'b1; phase = 2; scan_idx = 1;
          end else delay--;
          2: if ($urandom_range(0, 2) != 0) begin
            fft_mag_ready_i = 1'b1;
            fft_mag_i = 16'(mag_tab[fft_index_o]);
            check_eq("scan_index", 32'(fft_index_o), scan_idx);
            if (scan_idx == BINS - 1) phase = 3;
            scan_idx++;
          end else fft_mag_ready_i = 1'b0;
          default: fft_mag_ready_i = 1'b0;
        endcase
      end
    end
  end

  initial begin : fwd_monitor
    logic lv;
    logic signed [15:0] ld;
    forever begin
      @(posedge clk);
      lv = adc_valid_i;
      ld = adc_data_i;
      #1;
      if (fft_stream_active_o) begin
        fwd_count++;
        check_eq("fwd_latency", 32'(lv), 1);
        check_eq("fwd_data", 32'(fft_real_o), 32'(ld));
      end
    end
  end

  task automatic run_frame(input int mode, input int gap, input int exp_hold, input int n_drop, input int abort_at);
    int hold_cnt, sent, inj, waited, g, eb, em, fwd_base;
    core_mode = mode;
    fwd_base = fwd_count;
    hold_cnt = 0; inj = 0;
    while (fft_reset_o && hold_cnt < 200) begin
      if (n_drop > 0 && inj < 5 && hold_cnt % 2 == 0) begin
        adc_valid_i = 1'b1; adc_data_i = 16'($urandom); inj++;
      end else adc_valid_i = 1'b0;
      hold_cnt++;
      @(negedge clk);
    end
    adc_valid_i = 1'b0;
    exp_drops += inj;
    check_eq("hold_cycles", hold_cnt, exp_hold);
    sent = 0;
    while (sent < N && !(abort_at > 0 && sent == abort_at)) begin
      adc_valid_i = 1'b1;
      adc_data_i = (mode == 1) ? sine_sample(drv_n) : 16'($urandom);
      drv_n++; sent++;
      @(negedge clk);
      adc_valid_i = 1'b0;
      g = (gap > 0) ? gap : int'($urandom_range(1, 3));
      repeat (g - 1) @(negedge clk);
    end
    if (abort_at > 0) return;
    for (int i = inj; i < n_drop; i++) begin
      adc_valid_i = 1'b1; adc_data_i = 16'($urandom);
      exp_drops++;
      @(negedge clk);
      adc_valid_i = 1'b0;
      @(negedge clk);
    end
    waited = 0;
    while (!frame_valid_o && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("valid_timeout", 32'(frame_valid_o), 1);
    check_eq("fwd_count", fwd_count - fwd_base, N);
    ref_peak(eb, em);
    check_eq("peak_bin", 32'(peak_bin_o), eb);
    check_eq("peak_mag", 32'(peak_mag_o), em);
    check_eq("dropped", 32'(dropped_o), exp_drops);
  endtask

  task automatic accept(input int delay, input bit hs_sample);
    bit stable;
    logic [IW-1:0] sb;
    logic [15:0] sm;
    logic en;
    stable = 1'b1; sb = peak_bin_o; sm = peak_mag_o;
    repeat (delay) begin
      @(negedge clk);
      if (frame_valid_o !== 1'b1 || peak_bin_o !== sb || peak_mag_o !== sm || fft_reset_o !== 1'b0)
        stable = 1'b0;
    end
    if (delay > 0) check_eq("stall_stable", 32'(stable), 1);
    en = enable;
    frame_ready_i = 1'b1;
    if (hs_sample) begin
      adc_valid_i = 1'b1; exp_drops++;
    end
    @(negedge clk);
    frame_ready_i = 1'b0;
    adc_valid_i = 1'b0;
    check_eq("valid_fall", 32'(frame_valid_o), 0);
    check_eq("busy_after_hs", 32'(busy_o), 32'(en));
    check_eq("reset_after_hs", 32'(fft_reset_o), 1);
  endtask

  initial begin : main
    bit saw_valid;
    for (int m = 0; m < N; m++) begin
      ct[m] = $cos(2.0 * 3.14159265358979 * m / N);
      st[m] = $sin(2.0 * 3.14159265358979 * m / N);
    end
    reset = 1'b0; enable = 1'b0; adc_valid_i = 1'b0; adc_data_i = '0; frame_ready_i = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_fft_reset", 32'(fft_reset_o), 1);
    check_eq("rst_stream", 32'(fft_stream_active_o), 0);
    check_eq("rst_real", 32'(fft_real_o), 0);
    check_eq("rst_index", 32'(fft_index_o), 0);
    check_eq("rst_peak_bin", 32'(peak_bin_o), 0);
    check_eq("rst_peak_mag", 32'(peak_mag_o), 0);
    check_eq("rst_valid", 32'(frame_valid_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_dropped", 32'(dropped_o), 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("idle_busy", 32'(busy_o), 0);
    check_eq("idle_fft_reset", 32'(fft_reset_o), 1);

    enable = 1'b1;
    run_frame(1, 21, RC + 1, 0, 0);
    check_eq("sine_bin", 32'(peak_bin_o), 8);
    accept(int'($urandom_range(3, 10)), 1'b0);

    run_frame(2, 0, RC, 0, 0);
    check_eq("tie_bin", 32'(peak_bin_o), 5);
    check_eq("tie_mag", 32'(peak_mag_o), 100);
    accept(2, 1'b1);

    run_frame(0, 0, RC, 50, 0);
    accept(1, 1'b0);

    run_frame(0, 0, RC, 0, 0);
    accept(300, 1'b0);

    enable = 1'b0;
    run_frame(0, 0, RC, 0, 0);
    accept(int'($urandom_range(0, 4)), 1'b0);

    repeat (3) @(negedge clk);
    enable = 1'b1;
    run_frame(0, 0, RC + 1, 0, 600);
    reset = 1'b0;
    @(negedge clk);
    exp_drops = 0;
    check_eq("abort_busy", 32'(busy_o), 0);
    check_eq("abort_fft_reset", 32'(fft_reset_o), 1);
    check_eq("abort_valid", 32'(frame_valid_o), 0);
    check_eq("abort_index", 32'(fft_index_o), 0);
    check_eq("abort_dropped", 32'(dropped_o), 0);
    reset = 1'b1;
    enable = 1'b0;
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (frame_valid_o) saw_valid = 1'b1;
    end
    check_eq("no_partial_result", 32'(saw_valid), 0);

    enable = 1'b1;
    run_frame(0, 0, RC + 1, 0, 0);
    enable = 1'b0;
    accept(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
